pattern_scan_ctrl: RTL

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pattern_scan_ctrl.sv
// Serial 4-bit pattern detector over a captured word, scanned MSB first.
// Produces a per-word match count and a per-bit match map.
//
// state | meaning
// IDLE  | ready for a word; configuration writes accepted
// SCAN  | one bit of the captured word processed per cycle
// DONE  | one-cycle result strobe
module pattern_scan_ctrl #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [WORD_W-1:0] match_map
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic               last_bit;
    logic               bit_in;
    logic               hit;
    logic [WORD_W-1:0]  word;
    logic [IDX_W-1:0]   bits_left;
    logic [2:0]         hist;
    logic [1:0]         hist_len;
    logic [3:0]         pattern;
    logic               overlap;
    logic [CNT_W-1:0]   acc_cnt;
    logic [WORD_W-1:0]  acc_map;

    assign bit_in   = word[WORD_W-1];
    assign last_bit = (bits_left == '0);
    // hist_len saturates at 3, which is all the detector needs to know
    assign hit      = (hist_len == 2'd3) && ({hist, bit_in} == pattern);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern   <= 4'b1001;
            overlap   <= 1'b0;
            word      <= '0;
            bits_left <= '0;
            hist      <= '0;
            hist_len  <= '0;
            acc_cnt   <= '0;
            acc_map   <= '0;
            match_cnt <= '0;
            match_map <= '0;
        end else begin
            // config lands on the same edge as an accept, so that word sees it
            if (state == IDLE && cfg_we) begin
                pattern <= cfg_pattern;
                overlap <= cfg_overlap;
            end
            if (accept) begin
                word      <= in_data;
                bits_left <= IDX_W'(WORD_W - 1);
                hist      <= '0;
                hist_len  <= '0;
                acc_cnt   <= '0;
                acc_map   <= '0;
            end else if (state == SCAN) begin
                word      <= word << 1;
                bits_left <= bits_left - IDX_W'(1);
                hist      <= {hist[1:0], bit_in};
                if (hit && !overlap) begin
                    hist_len <= 2'd0;
                end else if (hist_len != 2'd3) begin
                    hist_len <= hist_len + 2'd1;
                end
                acc_cnt            <= acc_cnt + CNT_W'(hit);
                acc_map[bits_left] <= hit;
                // the final bit's match is folded in directly as results are published
                if (last_bit) begin
                    match_cnt <= acc_cnt + CNT_W'(hit);
                    match_map <= acc_map | {{(WORD_W-1){1'b0}}, hit};
                end
            end
        end
    end

endmodule
